// File: rtl/regfile_write_arbiter_pkg.sv
// Shared types and constants for the register-file write arbiter.
// Requester indices double as round-robin pointer encodings.
package regfile_write_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;
  localparam int NUM_REGS   = 32;

  localparam int REQ_ALU  = 0;
  localparam int REQ_LONG = 1;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;

  function automatic logic is_x0(
    input logic [REG_ADDR_W-1:0] a
  );
    return a == '0;
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_scoreboard.sv
// Busy vector of registers awaiting a long-latency writeback.
// A set and a clear of the same index at one edge leaves it set.
module regfile_scoreboard
  import regfile_write_arbiter_pkg::*;
(
  input  logic                  clock,
  input  logic                  resetN,
  input  logic                  setEn,
  input  logic [REG_ADDR_W-1:0] setIdx,
  input  logic                  clrEn,
  input  logic [REG_ADDR_W-1:0] clrIdx,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  output logic                  hazard
);

  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busyNext;

  always_comb begin
    busyNext = busy;
    if (clrEn) busyNext[clrIdx] = 1'b0;
    if (setEn) busyNext[setIdx] = 1'b1;
    busyNext[0] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (!resetN) begin
      busy <= '0;
    end else begin
      busy <= busyNext;
    end
  end

  assign hazard = busy[rs1] | busy[rs2];

endmodule

// File: rtl/regfile_write_arbiter.sv
// Two-requester arbiter for the register-file write port.
// Define REGFILE_WRITE_ARBITER_SCOREBOARD_EN to add the busy scoreboard.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int FIXED_PRIORITY = 0,
  parameter int MAX_WAIT       = 4
) (
  input  logic                  clock,
  input  logic                  resetN,
  input  logic                  req0Valid,
  output logic                  req0Ready,
  input  logic [REG_ADDR_W-1:0] req0Rd,
  input  logic [XLEN-1:0]       req0Data,
  input  logic                  req1Valid,
  output logic                  req1Ready,
  input  logic [REG_ADDR_W-1:0] req1Rd,
  input  logic [XLEN-1:0]       req1Data,
  output logic                  writeRegister,
  output logic [REG_ADDR_W-1:0] rd,
  output logic [XLEN-1:0]       dataToWrite,
  input  logic                  issueValid,
  input  logic [REG_ADDR_W-1:0] issueRd,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  output logic                  hazard
);

  localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

  logic                  rrNext;
  logic [3:0]            waitCnt;
  logic                  gnt0;
  logic                  gnt1;
  wb_req_t               sel;
  logic                  weQ;
  logic [REG_ADDR_W-1:0] rdQ;
  logic [XLEN-1:0]       dataQ;

  // Readies are held low during reset so nothing is consumed then.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (FIXED_PRIORITY != 0) begin
      gnt1 = req1Valid & (~req0Valid | (waitCnt == MAX_W));
      gnt0 = req0Valid & ~gnt1;
    end else begin
      gnt0 = req0Valid & (~req1Valid | (rrNext == 1'(REQ_ALU)));
      gnt1 = req1Valid & ~gnt0;
    end
    gnt0 = gnt0 & resetN;
    gnt1 = gnt1 & resetN;
  end

  always_comb begin
    sel = '0;
    unique case (1'b1)
      gnt0: sel = '{rd: req0Rd, data: req0Data};
      gnt1: sel = '{rd: req1Rd, data: req1Data};
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetN) begin
      rrNext  <= 1'(REQ_ALU);
      waitCnt <= '0;
      weQ     <= 1'b0;
      rdQ     <= '0;
      dataQ   <= '0;
    end else begin
      weQ <= 1'b0;
      if (gnt0 | gnt1) begin
        rrNext <= gnt0 ? 1'(REQ_LONG) : 1'(REQ_ALU);
        if (!is_x0(sel.rd)) begin
          weQ   <= 1'b1;
          rdQ   <= sel.rd;
          dataQ <= sel.data;
        end
      end
      if (gnt1 || !req1Valid) begin
        waitCnt <= '0;
      end else begin
        waitCnt <= waitCnt + 4'd1;
      end
    end
  end

  assign req0Ready     = gnt0;
  assign req1Ready     = gnt1;
  // Reset suppresses a pending write before the regfile samples it.
  assign writeRegister = weQ & resetN;
  assign rd            = rdQ;
  assign dataToWrite   = dataQ;

`ifdef REGFILE_WRITE_ARBITER_SCOREBOARD_EN
  regfile_scoreboard u_sb (
    .clock  (clock),
    .resetN (resetN),
    .setEn  (issueValid),
    .setIdx (issueRd),
    .clrEn  (gnt1),
    .clrIdx (req1Rd),
    .rs1    (rs1),
    .rs2    (rs2),
    .hazard (hazard)
  );
`else
  logic unusedSb;
  assign unusedSb = ^{issueValid, issueRd, rs1, rs2};
  assign hazard   = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench: round-robin and fixed-priority instances share inputs.
module tb_regfile_write_arbiter;

`ifdef REGFILE_WRITE_ARBITER_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        resetN;
  logic        req0Valid, req1Valid;
  logic [4:0]  req0Rd, req1Rd;
  logic [31:0] req0Data, req1Data;
  logic        issueValid;
  logic [4:0]  issueRd, rs1, rs2;

  logic        r_rdy0, r_rdy1, r_we, r_haz;
  logic [4:0]  r_rd;
  logic [31:0] r_data;
  logic        f_rdy0, f_rdy1, f_we, f_haz;
  logic [4:0]  f_rd;
  logic [31:0] f_data;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  regfile_write_arbiter #(.FIXED_PRIORITY(0), .MAX_WAIT(4)) dut_rr (
    .clock(clock), .resetN(resetN),
    .req0Valid(req0Valid), .req0Ready(r_rdy0),
    .req0Rd(req0Rd), .req0Data(req0Data),
    .req1Valid(req1Valid), .req1Ready(r_rdy1),
    .req1Rd(req1Rd), .req1Data(req1Data),
    .writeRegister(r_we), .rd(r_rd), .dataToWrite(r_data),
    .issueValid(issueValid), .issueRd(issueRd),
    .rs1(rs1), .rs2(rs2), .hazard(r_haz)
  );

  regfile_write_arbiter #(.FIXED_PRIORITY(1), .MAX_WAIT(4)) dut_fp (
    .clock(clock), .resetN(resetN),
    .req0Valid(req0Valid), .req0Ready(f_rdy0),
    .req0Rd(req0Rd), .req0Data(req0Data),
    .req1Valid(req1Valid), .req1Ready(f_rdy1),
    .req1Rd(req1Rd), .req1Data(req1Data),
    .writeRegister(f_we), .rd(f_rd), .dataToWrite(f_data),
    .issueValid(issueValid), .issueRd(issueRd),
    .rs1(rs1), .rs2(rs2), .hazard(f_haz)
  );

  typedef struct {
    logic        rst;
    logic        v0;
    logic [4:0]  rd0;
    logic [31:0] d0;
    logic        v1;
    logic [4:0]  rd1;
    logic [31:0] d1;
    logic        e0;
    logic        e1;
    logic        ewe;
    logic        chk;
    logic [4:0]  erd;
    logic [31:0] edata;
  } vec_t;

  vec_t tbl[14];

  function automatic vec_t mk(
    input logic rst, input logic v0, input logic [4:0] rd0,
    input logic [31:0] d0, input logic v1, input logic [4:0] rd1,
    input logic [31:0] d1, input logic e0, input logic e1,
    input logic ewe, input logic chk, input logic [4:0] erd,
    input logic [31:0] edata
  );
    vec_t v;
    v.rst = rst; v.v0 = v0; v.rd0 = rd0; v.d0 = d0;
    v.v1 = v1; v.rd1 = rd1; v.d1 = d1;
    v.e0 = e0; v.e1 = e1; v.ewe = ewe; v.chk = chk;
    v.erd = erd; v.edata = edata;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    req0Valid = 0; req0Rd = 0; req0Data = 0;
    req1Valid = 0; req1Rd = 0; req1Data = 0;
    issueValid = 0; issueRd = 0; rs1 = 0; rs2 = 0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    idle_inputs();
    resetN = 0;
    @(posedge clock);
    @(negedge clock);
    resetN = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic prevWe;
    logic [9:0] fpPat;
    logic [4:0] fpPat2;

    resetN = 0;
    idle_inputs();

    tbl[0]  = mk(0,1,5,32'h11,1,6,32'h22, 0,0, 0,1,0,32'h0);
    tbl[1]  = mk(1,1,5,32'h11,1,6,32'h22, 1,0, 1,1,5,32'h11);
    tbl[2]  = mk(1,1,5,32'h11,1,6,32'h22, 0,1, 1,1,6,32'h22);
    tbl[3]  = mk(1,1,5,32'h11,1,6,32'h22, 1,0, 1,1,5,32'h11);
    tbl[4]  = mk(1,1,5,32'h11,1,6,32'h22, 0,1, 1,1,6,32'h22);
    tbl[5]  = mk(1,1,0,32'hDEAD,0,0,32'h0, 1,0, 0,0,0,32'h0);
    tbl[6]  = mk(1,0,0,32'h0,0,0,32'h0, 0,0, 0,0,0,32'h0);
    tbl[7]  = mk(1,0,0,32'h0,1,9,32'h99, 0,1, 1,1,9,32'h99);
    tbl[8]  = mk(1,0,0,32'h0,0,0,32'h0, 0,0, 0,1,9,32'h99);
    tbl[9]  = mk(1,1,3,32'h33,1,3,32'h44, 1,0, 1,1,3,32'h33);
    tbl[10] = mk(1,1,3,32'h33,1,3,32'h44, 0,1, 1,1,3,32'h44);
    tbl[11] = mk(1,1,5,32'h55,0,0,32'h0, 1,0, 1,1,5,32'h55);
    tbl[12] = mk(0,1,5,32'h11,1,6,32'h22, 0,0, 0,1,0,32'h0);
    tbl[13] = mk(1,1,5,32'h11,1,6,32'h22, 1,0, 1,1,5,32'h11);

    prevWe = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clock);
      resetN = tbl[i].rst;
      req0Valid = tbl[i].v0; req0Rd = tbl[i].rd0; req0Data = tbl[i].d0;
      req1Valid = tbl[i].v1; req1Rd = tbl[i].rd1; req1Data = tbl[i].d1;
      #1;
      chk($sformatf("v%0d we_pre", i), r_we, prevWe & tbl[i].rst);
      chk($sformatf("v%0d rdy0", i), r_rdy0, tbl[i].e0);
      chk($sformatf("v%0d rdy1", i), r_rdy1, tbl[i].e1);
      @(posedge clock);
      #1;
      chk($sformatf("v%0d we", i), r_we, tbl[i].ewe);
      if (tbl[i].chk) begin
        chk($sformatf("v%0d rd", i), r_rd, tbl[i].erd);
        chk($sformatf("v%0d data", i), r_data, tbl[i].edata);
      end
      prevWe = tbl[i].ewe;
    end

    // Fixed priority: four req0 grants, then a forced req1 grant.
    do_reset();
    req0Valid = 1; req0Rd = 5; req0Data = 32'h11;
    req1Valid = 1; req1Rd = 6; req1Data = 32'h22;
    fpPat = 10'b1000010000;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk($sformatf("fp%0d rdy1", i), f_rdy1, fpPat[i]);
      chk($sformatf("fp%0d rdy0", i), f_rdy0, !fpPat[i]);
      chk($sformatf("rr%0d rdy0", i), r_rdy0, (i % 2) == 0);
      @(posedge clock);
      #1;
      chk($sformatf("fp%0d we", i), f_we, 1'b1);
      chk($sformatf("fp%0d rd", i), f_rd, fpPat[i] ? 5'd6 : 5'd5);
      chk($sformatf("rr%0d rd", i), r_rd, (i % 2) ? 5'd6 : 5'd5);
      @(negedge clock);
    end

    // Counter clears when req1 drops valid.
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    req1Valid = 0;
    @(negedge clock);
    req1Valid = 1;
    fpPat2 = 5'b10000;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("fpclr%0d rdy1", i), f_rdy1, fpPat2[i]);
      @(negedge clock);
    end

    // Scoreboard set / clear ordering.
    do_reset();
    issueValid = 1; issueRd = 7;
    #1;
    chk("sb empty", r_haz, 1'b0);
    @(negedge clock);
    issueValid = 0; rs1 = 7;
    #1;
    chk("sb rs1 busy", r_haz, SB);
    chk("sb rs1 busy fp", f_haz, SB);
    rs1 = 0; rs2 = 7;
    #1;
    chk("sb rs2 busy", r_haz, SB);
    @(negedge clock);
    issueValid = 1; issueRd = 7;
    req1Valid = 1; req1Rd = 7; req1Data = 32'h77;
    #1;
    chk("sb clr rdy1", r_rdy1, 1'b1);
    @(posedge clock);
    #1;
    chk("sb set wins", r_haz, SB);
    @(negedge clock);
    issueValid = 0;
    @(posedge clock);
    #1;
    chk("sb cleared", r_haz, 1'b0);
    @(negedge clock);
    req1Valid = 0; issueValid = 1; issueRd = 0;
    @(negedge clock);
    issueValid = 0; rs1 = 0; rs2 = 0;
    #1;
    chk("sb x0", r_haz, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
